// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - bundle widths, bit positions and FSM encoding for the ID/EX boundary
package id_ex_stage_pkg;

    localparam int EX_D_W  = 7;
    localparam int MEM_D_W = 2;
    localparam int WB_D_W  = 2;

    localparam int EX_REGDST   = 6;
    localparam int EX_ALUSRC   = 5;
    localparam int MEM_READ    = 0;
    localparam int MEM_WRITE   = 1;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int REG_RA = 31;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // rt is a source unless the instruction takes an immediate and is not a store
    function automatic logic uses_rt(input logic [EX_D_W-1:0] ex_d, input logic [MEM_D_W-1:0] mem_d);
        return ~(ex_d[EX_ALUSRC] & ~mem_d[MEM_WRITE]);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// rtl/id_ex_stage_hazard.sv - combinational load-use and in-flight register-write detection
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic          id_uses_rt_i,
    input  logic          ex_valid_i,
    input  logic          ex_memread_i,
    input  logic          ex_regwrite_i,
    input  logic [RW-1:0] ex_dst_i,
    input  logic          mem_regwrite_i,
    input  logic          wb_regwrite_i,
    output logic          load_use_o,
    output logic          writes_inflight_o
);

    logic dst_nonzero;
    logic rs_match;
    logic rt_match;

    assign dst_nonzero = (ex_dst_i != '0);
    assign rs_match    = (ex_dst_i == id_rs_i);
    assign rt_match    = id_uses_rt_i & (ex_dst_i == id_rt_i);

    assign load_use_o        = ex_valid_i & ex_memread_i & dst_nonzero & (rs_match | rt_match);
    assign writes_inflight_o = (ex_valid_i & ex_regwrite_i) | mem_regwrite_i | wb_regwrite_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles, syscall drain and flush squash
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [31:0]         id_instr,
    input  logic [DW-1:0]       id_pc4,
    input  logic [EX_D_W-1:0]  id_ex_d,
    input  logic [MEM_D_W-1:0] id_mem_d,
    input  logic [WB_D_W-1:0]  id_wb_d,
    input  logic                id_syscall,
    input  logic                id_jal,
    input  logic [DW-1:0]       id_rs_data,
    input  logic [DW-1:0]       id_rt_data,
    input  logic [DW-1:0]       id_imm,
    input  logic                flush,
    input  logic                ex_stall,
    input  logic                mem_regwrite,
    input  logic                wb_regwrite,
    output logic                stall_id,
    output logic                ex_valid,
    output logic [EX_D_W-1:0]  ex_ex_d,
    output logic [MEM_D_W-1:0] ex_mem_d,
    output logic [WB_D_W-1:0]  ex_wb_d,
    output logic                ex_syscall,
    output logic                ex_jal,
    output logic [DW-1:0]       ex_rs_data,
    output logic [DW-1:0]       ex_rt_data,
    output logic [DW-1:0]       ex_imm,
    output logic [DW-1:0]       ex_pc4,
    output logic [RW-1:0]       ex_rs,
    output logic [RW-1:0]       ex_rt,
    output logic [RW-1:0]       ex_dst
);

    logic                valid_q;
    logic [EX_D_W-1:0]  ex_d_q;
    logic [MEM_D_W-1:0] mem_d_q;
    logic [WB_D_W-1:0]  wb_d_q;
    logic                syscall_q;
    logic                jal_q;
    logic [DW-1:0]       rs_data_q;
    logic [DW-1:0]       rt_data_q;
    logic [DW-1:0]       imm_q;
    logic [DW-1:0]       pc4_q;
    logic [RW-1:0]       rs_q;
    logic [RW-1:0]       rt_q;
    logic [RW-1:0]       dst_q;

    state_e              state_q;
    state_e              state_d;
    logic                kill_q;

    logic [RW-1:0]       id_rs;
    logic [RW-1:0]       id_rt;
    logic [RW-1:0]       id_dst;
    logic                load_use;
    logic                writes_inflight;
    logic                enter_drain;
    logic                drain_busy;
    logic                squash;
    logic                do_clear;
    logic                do_load;

    assign id_rs = RW'(id_instr[25:21]);
    assign id_rt = RW'(id_instr[20:16]);

    always_comb begin
        id_dst = id_rt;
        if (id_jal) begin
            id_dst = RW'(REG_RA);
        end else if (id_ex_d[EX_REGDST]) begin
            id_dst = RW'(id_instr[15:11]);
        end
    end

    hazard_detect #(.RW(RW)) u_hazard (
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (uses_rt(id_ex_d, id_mem_d)),
        .ex_valid_i        (valid_q),
        .ex_memread_i      (mem_d_q[MEM_READ]),
        .ex_regwrite_i     (wb_d_q[WB_REGWRITE]),
        .ex_dst_i          (dst_q),
        .mem_regwrite_i    (mem_regwrite),
        .wb_regwrite_i     (wb_regwrite),
        .load_use_o        (load_use),
        .writes_inflight_o (writes_inflight)
    );

    // DRAIN only holds the syscall back while writes remain; the cycle they clear it is admitted
    assign enter_drain = (state_q == ST_RUN) & id_valid & id_syscall & writes_inflight;
    assign drain_busy  = enter_drain | ((state_q == ST_DRAIN) & writes_inflight);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (enter_drain) state_d = ST_DRAIN;
            ST_DRAIN: if (!writes_inflight) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign squash   = flush | kill_q;
    assign stall_id = ex_stall | ((load_use | drain_busy) & ~squash);
    assign do_clear = reset | (~ex_stall & (squash | load_use | drain_busy));
    assign do_load  = ~reset & ~ex_stall & ~do_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            kill_q  <= 1'b0;
        end else if (ex_stall) begin
            // a flush seen while EX is frozen must still squash once the stall lifts
            if (flush) kill_q <= 1'b1;
        end else if (squash) begin
            state_q <= ST_RUN;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_clear) begin
            valid_q   <= 1'b0;
            ex_d_q    <= '0;
            mem_d_q   <= '0;
            wb_d_q    <= '0;
            syscall_q <= 1'b0;
            jal_q     <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
        end else if (do_load) begin
            valid_q   <= id_valid;
            ex_d_q    <= id_ex_d;
            mem_d_q   <= id_mem_d;
            wb_d_q    <= id_wb_d;
            syscall_q <= id_syscall;
            jal_q     <= id_jal;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            pc4_q     <= id_pc4;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            dst_q     <= id_dst;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ex_d    = ex_d_q;
    assign ex_mem_d   = mem_d_q;
    assign ex_wb_d    = wb_d_q;
    assign ex_syscall = syscall_q;
    assign ex_jal     = jal_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_dst     = dst_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [6:0]  id_ex_d;
    logic [1:0]  id_mem_d;
    logic [1:0]  id_wb_d;
    logic        id_syscall;
    logic        id_jal;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic        flush;
    logic        ex_stall;
    logic        mem_regwrite;
    logic        wb_regwrite;
    logic        stall_id;
    logic        ex_valid;
    logic [6:0]  ex_ex_d;
    logic [1:0]  ex_mem_d;
    logic [1:0]  ex_wb_d;
    logic        ex_syscall;
    logic        ex_jal;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc4;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
        .id_ex_d(id_ex_d), .id_mem_d(id_mem_d), .id_wb_d(id_wb_d), .id_syscall(id_syscall),
        .id_jal(id_jal), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .flush(flush), .ex_stall(ex_stall), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_ex_d(ex_ex_d), .ex_mem_d(ex_mem_d),
        .ex_wb_d(ex_wb_d), .ex_syscall(ex_syscall), .ex_jal(ex_jal), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst)
    );

    typedef struct packed {
        logic        valid;
        logic [6:0]  exd;
        logic [1:0]  memd;
        logic [1:0]  wbd;
        logic        sys;
        logic        jal;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
    } ex_t;

    ex_t got;
    assign got = '{ex_valid, ex_ex_d, ex_mem_d, ex_wb_d, ex_syscall, ex_jal,
                   ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_dst};

    ex_t m_ex;
    bit  m_drain;
    bit  m_kill;

    function automatic logic [31:0] mk_r(int rs, int rt, int rd);
        return (rs << 21) | (rt << 16) | (rd << 11) | 32'h20;
    endfunction

    function automatic logic [31:0] mk_i(int op, int rs, int rt, int imm);
        return (op << 26) | (rs << 21) | (rt << 16) | (imm & 32'hffff);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_instr = 0; id_pc4 = 0; id_ex_d = 0; id_mem_d = 0; id_wb_d = 0;
        id_syscall = 0; id_jal = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        flush = 0; ex_stall = 0; mem_regwrite = 0; wb_regwrite = 0;
    endtask

    task automatic put(input logic [31:0] instr, input logic [6:0] exd, input logic [1:0] memd,
                       input logic [1:0] wbd, input logic jal, input logic sys);
        id_valid = 1; id_instr = instr; id_ex_d = exd; id_mem_d = memd; id_wb_d = wbd;
        id_jal = jal; id_syscall = sys; id_pc4 = $urandom; id_rs_data = $urandom;
        id_rt_data = $urandom; id_imm = $urandom;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Reference model: computes expected stall and next EX contents from the boundary rules
    function automatic bit model_lu();
        int  rs = (id_instr >> 21) & 31;
        int  rt = (id_instr >> 16) & 31;
        bit  alu_imm = id_ex_d[5];
        bit  store = id_mem_d[1];
        bit  rt_src = !(alu_imm && !store);
        return m_ex.valid && m_ex.memd[0] && m_ex.dst != 0 &&
               (m_ex.dst == rs || (rt_src && m_ex.dst == rt));
    endfunction

    function automatic bit model_wants_drain();
        bit inflight = (m_ex.valid && m_ex.wbd[1]) || mem_regwrite || wb_regwrite;
        if (m_drain) return inflight;
        return id_valid && id_syscall && inflight;
    endfunction

    function automatic bit model_stall();
        return ex_stall || ((model_lu() || model_wants_drain()) && !flush && !m_kill);
    endfunction

    task automatic model_step();
        bit   lu = model_lu();
        bit   wd = model_wants_drain();
        ex_t  n;
        if (reset) begin
            m_ex = '0; m_drain = 0; m_kill = 0;
        end else if (ex_stall) begin
            if (flush) m_kill = 1;
        end else if (flush || m_kill) begin
            m_ex = '0; m_kill = 0; m_drain = 0;
        end else begin
            m_drain = wd;
            if (lu || wd) begin
                m_ex = '0;
            end else begin
                n.valid = id_valid; n.exd = id_ex_d; n.memd = id_mem_d; n.wbd = id_wb_d;
                n.sys = id_syscall; n.jal = id_jal; n.rsd = id_rs_data; n.rtd = id_rt_data;
                n.imm = id_imm; n.pc4 = id_pc4;
                n.rs = 5'((id_instr >> 21) & 31);
                n.rt = 5'((id_instr >> 16) & 31);
                n.dst = id_jal ? 5'd31 : (id_ex_d[6] ? 5'((id_instr >> 11) & 31) : n.rt);
                m_ex = n;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_id); end
        tick();
        reset = 0;
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", got); end
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall_after got=%0b want=0", stall_id); end
    endtask

    task automatic test_load_use();
        do_reset();
        put(mk_i(6'h23, 9, 8, 0), 7'h20, 2'b01, 2'b11, 0, 0);
        tick();
        put(mk_r(8, 11, 10), 7'h42, 2'b00, 2'b10, 0, 0);
        #1;
        total++;
        if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", stall_id); end
        tick();
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0b want=0", ex_valid); end
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%0b want=0", stall_id); end
        tick();
        total++;
        if ({ex_valid, ex_dst, ex_rs, ex_rt} !== {1'b1, 5'd10, 5'd8, 5'd11}) begin
            bad++; $display("FAIL lu_add_in_ex got=%0b/%0d/%0d/%0d want=1/10/8/11", ex_valid, ex_dst, ex_rs, ex_rt);
        end
        // flush coinciding with load-use wins
        put(mk_i(6'h23, 9, 8, 0), 7'h20, 2'b01, 2'b11, 0, 0);
        tick();
        put(mk_r(8, 11, 10), 7'h42, 2'b00, 2'b10, 0, 0);
        flush = 1;
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_flush_stall got=%0b want=0", stall_id); end
        tick();
        flush = 0;
        total++;
        if (got !== '0) begin bad++; $display("FAIL lu_flush_bubble got=%h want=0", got); end
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        put(mk_i(6'h23, 9, 8, 0), 7'h20, 2'b01, 2'b11, 0, 0);
        tick();
        put(mk_i(6'h08, 9, 12, 4), 7'h20, 2'b00, 2'b10, 0, 0);
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL nf_addi got=%0b want=0", stall_id); end
        tick();
        put(mk_i(6'h23, 9, 0, 0), 7'h20, 2'b01, 2'b11, 0, 0);
        tick();
        put(mk_r(0, 0, 1), 7'h42, 2'b00, 2'b10, 0, 0);
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL nf_zero_reg got=%0b want=0", stall_id); end
        tick();
        total++;
        if ({ex_valid, ex_dst} !== {1'b1, 5'd1}) begin
            bad++; $display("FAIL nf_add_loaded got=%0b/%0d want=1/1", ex_valid, ex_dst);
        end
    endtask

    task automatic test_syscall_drain();
        logic [3:0] exp_stall = 4'b0111;
        logic [3:0] memw = 4'b0011;
        logic [3:0] wbw  = 4'b0110;
        int stalled = 0;
        do_reset();
        put(mk_i(6'h08, 0, 2, 1), 7'h20, 2'b00, 2'b10, 0, 0);
        tick();
        put(32'h0000000C, 7'h00, 2'b00, 2'b00, 0, 1);
        for (int c = 0; c < 4; c++) begin
            mem_regwrite = memw[c];
            wb_regwrite  = wbw[c];
            #1;
            total++;
            if (stall_id !== exp_stall[c]) begin
                bad++; $display("FAIL drain_stall_c%0d got=%0b want=%0b", c, stall_id, exp_stall[c]);
            end
            if (stall_id === 1'b1) stalled++;
            tick();
        end
        total++;
        if (stalled != 3) begin bad++; $display("FAIL drain_len got=%0d want=3", stalled); end
        total++;
        if ({ex_valid, ex_syscall} !== 2'b11) begin
            bad++; $display("FAIL drain_syscall got=%0b%0b want=11", ex_valid, ex_syscall);
        end
        idle_inputs();
    endtask

    task automatic test_flush_during_stall();
        do_reset();
        put(mk_r(5, 6, 7), 7'h42, 2'b00, 2'b10, 0, 0);
        tick();
        put(mk_r(1, 2, 3), 7'h42, 2'b00, 2'b10, 0, 0);
        ex_stall = 1;
        flush = 1;
        #1;
        total++;
        if (stall_id !== 1'b1) begin bad++; $display("FAIL fs_stall got=%0b want=1", stall_id); end
        tick();
        total++;
        if ({ex_valid, ex_dst} !== {1'b1, 5'd7}) begin
            bad++; $display("FAIL fs_hold got=%0b/%0d want=1/7", ex_valid, ex_dst);
        end
        ex_stall = 0;
        flush = 0;
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL fs_stall_release got=%0b want=0", stall_id); end
        tick();
        total++;
        if (got !== '0) begin bad++; $display("FAIL fs_bubble got=%h want=0", got); end
        tick();
        total++;
        if ({ex_valid, ex_dst} !== {1'b1, 5'd3}) begin
            bad++; $display("FAIL fs_resume got=%0b/%0d want=1/3", ex_valid, ex_dst);
        end
    endtask

    task automatic test_dst();
        do_reset();
        put({6'h03, 26'h10}, 7'h00, 2'b00, 2'b10, 1, 0);
        tick();
        total++;
        if ({ex_jal, ex_dst} !== {1'b1, 5'd31}) begin bad++; $display("FAIL dst_jal got=%0d want=31", ex_dst); end
        put(mk_r(6, 7, 5), 7'h42, 2'b00, 2'b10, 0, 0);
        tick();
        total++;
        if (ex_dst !== 5'd5) begin bad++; $display("FAIL dst_add got=%0d want=5", ex_dst); end
        put(mk_i(6'h0d, 3, 4, 1), 7'h20, 2'b00, 2'b10, 0, 0);
        tick();
        total++;
        if (ex_dst !== 5'd4) begin bad++; $display("FAIL dst_ori got=%0d want=4", ex_dst); end
    endtask

    task automatic test_reset_mid_state();
        do_reset();
        put(mk_i(6'h08, 0, 2, 1), 7'h20, 2'b00, 2'b10, 0, 0);
        tick();
        put(32'h0000000C, 7'h00, 2'b00, 2'b00, 0, 1);
        mem_regwrite = 1;
        tick();
        reset = 1;
        tick();
        reset = 0;
        total++;
        if (got !== '0) begin bad++; $display("FAIL rst_drain_outputs got=%h want=0", got); end
        id_valid = 0;
        #1;
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL rst_drain_state got=%0b want=0", stall_id); end
        idle_inputs();
        ex_stall = 1;
        flush = 1;
        tick();
        ex_stall = 0;
        flush = 0;
        reset = 1;
        tick();
        reset = 0;
        put(mk_r(1, 2, 9), 7'h42, 2'b00, 2'b10, 0, 0);
        tick();
        total++;
        if ({ex_valid, ex_dst} !== {1'b1, 5'd9}) begin
            bad++; $display("FAIL rst_kill_cleared got=%0b/%0d want=1/9", ex_valid, ex_dst);
        end
    endtask

    task automatic test_random();
        do_reset();
        m_ex = '0; m_drain = 0; m_kill = 0;
        for (int i = 0; i < 600; i++) begin
            int op = $urandom_range(0, 3);
            reset        = ($urandom_range(0, 59) == 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_instr     = (op == 0) ? mk_r($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3))
                                     : mk_i(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            id_ex_d      = 7'($urandom);
            id_mem_d     = 2'($urandom);
            id_wb_d      = 2'($urandom);
            id_jal       = ($urandom_range(0, 7) == 0);
            id_syscall   = ($urandom_range(0, 5) == 0);
            id_pc4       = $urandom;
            id_rs_data   = $urandom;
            id_rt_data   = $urandom;
            id_imm       = $urandom;
            flush        = ($urandom_range(0, 9) == 0);
            ex_stall     = ($urandom_range(0, 4) == 0);
            mem_regwrite = ($urandom_range(0, 2) == 0);
            wb_regwrite  = ($urandom_range(0, 2) == 0);
            #1;
            if (!reset) begin
                total++;
                if (stall_id !== model_stall()) begin
                    bad++; $display("FAIL rnd_stall_%0d got=%0b want=%0b", i, stall_id, model_stall());
                end
            end
            model_step();
            tick();
            total++;
            if (got !== m_ex) begin
                bad++; $display("FAIL rnd_ex_%0d got=%h want=%h", i, got, m_ex);
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_syscall_drain();
        test_flush_during_stall();
        test_dst();
        test_reset_mid_state();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
